// File: rtl/branch_predictor_table.sv
// Branch predictor table: a PC-indexed array of saturating counters plus a
// global history register, usable as a bimodal (MODE=0) or gshare (MODE=1)
// predictor.
//
// Ports:
//   clk, rst_n                      clock and synchronous active-low reset
//   lookup_valid, lookup_pc         IF-stage prediction request
//   pred_valid, pred_taken,         registered prediction, one cycle after the
//   pred_index                      request; pred_index travels down the pipe
//   update_valid, update_index,     EX-stage resolved outcome used for training
//   update_taken, update_mispredict
//   ghr                             current global history (debug)
//   mispredict_count                saturating count of resolved mispredicts
//
// Legal ranges: INDEX_BITS 1..12, CTR_BITS 1..4, HIST_BITS 1..INDEX_BITS.
// The table lives in flops so the whole array clears on reset.
module branch_predictor_table #(
    parameter int unsigned PC_WIDTH   = 32,
    parameter int unsigned INDEX_BITS = 4,
    parameter int unsigned CTR_BITS   = 2,
    parameter int unsigned HIST_BITS  = 4,
    parameter int unsigned MODE       = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  lookup_valid,
    input  logic [PC_WIDTH-1:0]   lookup_pc,
    output logic                  pred_valid,
    output logic                  pred_taken,
    output logic [INDEX_BITS-1:0] pred_index,
    input  logic                  update_valid,
    input  logic [INDEX_BITS-1:0] update_index,
    input  logic                  update_taken,
    input  logic                  update_mispredict,
    output logic [HIST_BITS-1:0]  ghr,
    output logic [15:0]           mispredict_count
);

    localparam int Depth = 1 << INDEX_BITS;
    localparam logic [CTR_BITS-1:0] CtrMax  = CTR_BITS'((1 << CTR_BITS) - 1);
    // Weakly not-taken; evaluates to 0 when CTR_BITS is 1.
    localparam logic [CTR_BITS-1:0] CtrInit = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

    logic [CTR_BITS-1:0]   ctr_q [Depth];
    logic [CTR_BITS-1:0]   ctr_d [Depth];
    logic [HIST_BITS-1:0]  ghr_q, ghr_d;
    logic [15:0]           mcount_q, mcount_d;
    logic                  pred_valid_q, pred_valid_d;
    logic                  pred_taken_q, pred_taken_d;
    logic [INDEX_BITS-1:0] pred_index_q, pred_index_d;

    logic [INDEX_BITS-1:0] base_idx;
    logic [INDEX_BITS-1:0] ghr_ext;
    logic [INDEX_BITS-1:0] lookup_idx;
    logic [CTR_BITS-1:0]   upd_cur;
    logic [CTR_BITS-1:0]   upd_next;
    logic                  unused_pc;

    // Word-aligned PC: the two byte-offset bits and the high bits never index.
    assign base_idx  = lookup_pc[INDEX_BITS+1:2];
    assign unused_pc = ^{lookup_pc[1:0], lookup_pc[PC_WIDTH-1:INDEX_BITS+2]};
    assign ghr_ext   = INDEX_BITS'(ghr_q);

    always_comb begin
        lookup_idx = base_idx;
        if (MODE == 1) begin
            lookup_idx = base_idx ^ ghr_ext;
        end
    end

    // Saturating step of the entry being trained this cycle.
    always_comb begin
        upd_cur  = ctr_q[update_index];
        upd_next = upd_cur;
        if (update_taken) begin
            if (upd_cur != CtrMax) begin
                upd_next = upd_cur + 1'b1;
            end
        end else begin
            if (upd_cur != '0) begin
                upd_next = upd_cur - 1'b1;
            end
        end
    end

    always_comb begin
        ctr_d    = ctr_q;
        ghr_d    = ghr_q;
        mcount_d = mcount_q;
        if (update_valid) begin
            ctr_d[update_index] = upd_next;
            // Shift in the resolved outcome; the cast keeps the low HIST_BITS,
            // which also covers the single-bit history case.
            ghr_d = HIST_BITS'({ghr_q, update_taken});
            if (update_mispredict && (mcount_q != 16'hFFFF)) begin
                mcount_d = mcount_q + 16'd1;
            end
        end
    end

    always_comb begin
        pred_valid_d = lookup_valid;
        pred_taken_d = pred_taken_q;
        pred_index_d = pred_index_q;
        if (lookup_valid) begin
            pred_index_d = lookup_idx;
            // Same-cycle update to the looked-up entry is forwarded.
            if (update_valid && (update_index == lookup_idx)) begin
                pred_taken_d = upd_next[CTR_BITS-1];
            end else begin
                pred_taken_d = ctr_q[lookup_idx][CTR_BITS-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < Depth; i++) begin
                ctr_q[i] <= CtrInit;
            end
            ghr_q        <= '0;
            mcount_q     <= '0;
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_index_q <= '0;
        end else begin
            ctr_q        <= ctr_d;
            ghr_q        <= ghr_d;
            mcount_q     <= mcount_d;
            pred_valid_q <= pred_valid_d;
            pred_taken_q <= pred_taken_d;
            pred_index_q <= pred_index_d;
        end
    end

    assign pred_valid       = pred_valid_q;
    assign pred_taken       = pred_taken_q;
    assign pred_index       = pred_index_q;
    assign ghr              = ghr_q;
    assign mispredict_count = mcount_q;

endmodule

// File: doc/branch_predictor_table.md
Name: branch_predictor_table

Overview:
- Parametrised successor to the single-entry 2-bit history predictor.
- Holds a PC-indexed table of 2^INDEX_BITS saturating counters, CTR_BITS wide, plus a global history register (GHR).
- Supports bimodal (MODE=0) or gshare (MODE=1) indexing.
- The IF stage issues lookups with a registered 1-cycle result. The EX stage returns resolved outcomes to train the table and GHR and to count mispredicts.

Parameters:
- PC_WIDTH, 32, instruction address width.
- INDEX_BITS, 4, log2 of table depth; legal range 1..12.
- CTR_BITS, 2, saturating counter width; legal range 1..4.
- HIST_BITS, 4, GHR width; legal range 1..INDEX_BITS.
- MODE, 0, 0 = bimodal, 1 = gshare.

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- rst_n, input, 1, synchronous active-low reset.
- lookup_valid, input, 1, IF requests a prediction this cycle.
- lookup_pc, input, PC_WIDTH, PC of the fetched instruction.
- pred_valid, output, 1, prediction outputs valid (1 cycle after lookup_valid).
- pred_taken, output, 1, predicted direction.
- pred_index, output, INDEX_BITS, table index used; carried down the pipe and returned as update_index.
- update_valid, input, 1, EX has resolved a branch this cycle.
- update_index, input, INDEX_BITS, index returned from the original lookup.
- update_taken, input, 1, resolved outcome.
- update_mispredict, input, 1, EX detected a wrong prediction.
- ghr, output, HIST_BITS, current global history (debug).
- mispredict_count, output, 16, saturating count of update_mispredict events.

Behaviour:
- Index calculation:
  - Base index: lookup_pc[INDEX_BITS+1:2]; bits [1:0] ignored.
  - MODE=1: the GHR value at the lookup cycle is XORed into the low HIST_BITS of the base index.
  - MODE=0: the GHR is still maintained but not used for indexing.
- Prediction rule: taken iff the counter MSB is 1.
- Counter update on update_valid:
  - update_taken=1: entry[update_index] increments, saturating at 2^CTR_BITS-1.
  - update_taken=0: entry decrements, saturating at 0.
- GHR update on update_valid: ghr <= {ghr[HIST_BITS-2:0], update_taken}. When HIST_BITS=1, ghr <= update_taken. GHR is updated non-speculatively at resolve only.
- Lookup latency:
  - lookup_valid at edge t gives pred_valid=1 with pred_taken/pred_index during cycle t+1.
  - pred_valid=0 when lookup_valid was 0 in the previous cycle; pred_taken and pred_index hold their last values.
- Simultaneous lookup and update, same cycle:
  - The lookup index uses the pre-update GHR.
  - If the computed lookup index equals update_index, pred_taken reflects the post-update counter value (write-through bypass).
  - Different indices proceed independently.
- Back-to-back lookups are accepted every cycle, with no stall or ready signal.
- Updates are accepted every cycle, with no ready signal.
- mispredict_count increments when update_valid && update_mispredict, and saturates at 16'hFFFF. update_mispredict without update_valid is ignored.
- Reset (rst_n=0 at an edge):
  - All counters are set to 2^(CTR_BITS-1)-1 (weakly not-taken; 0 when CTR_BITS=1).
  - ghr=0, pred_valid=0, pred_taken=0, pred_index=0, mispredict_count=0.
  - Reset overrides any concurrent lookup or update, including mid-stream.
  - pred_valid is 0 in the cycle after reset deasserts.
- The table is implemented in flops (no RAM macro) so that the full-table synchronous reset is possible.

Test Plan:
- Reset defaults: rst_n=0 for 2 cycles, then lookup pc=0x40 -> next cycle pred_valid=1, pred_taken=0, pred_index=0; ghr=0; mispredict_count=0.
- Bimodal training (MODE=0): 2 updates taken at index 3 (entry 1->2->3), then lookup pc=0x0C -> pred_taken=1. Then 3 not-taken updates -> counter 0. A 4th not-taken update -> counter stays 0 (saturation); lookup gives pred_taken=0.
- Upper saturation: 5 taken updates at index 5 followed by 1 not-taken -> counter=2, pred_taken=1.
- Bypass: entry 7 at 1, lookup pc=0x1C in the same cycle as a taken update at index 7 -> pred_taken=1 on the next cycle. Lookup pc=0x20 in the same cycle -> uses entry 8 only.
- Gshare (MODE=1): updates taken,taken,not-taken,taken -> ghr=4'b1101. Lookup pc=0x08 -> pred_index=2^13=4'hF.
- Mispredict count: 3 cycles with update_valid=1 and update_mispredict=1, plus 1 cycle with update_mispredict=1 and update_valid=0 -> mispredict_count=3. Assert rst_n=0 mid-stream -> all counters, ghr and mispredict_count return to reset values on the next edge.
